time_set_controller: RTL

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// Time/date set controller: debounced buttons drive a field editor
// over BCD shadow registers, committed to the datapath by load pulses.
// Ports: clk, rst (async, active-high); sw_mode selects clock/calendar;
// butt_change/increase/decrease raw active-low buttons; cur_* live
// BCD values in; set_* edited BCD values out; load_time/load_date
// one-cycle commit pulses; hold while editing; edit_field one-hot.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_mode,
  input  logic        butt_change,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_min,
  input  logic [7:0]  cur_sec,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_month,
  input  logic [15:0] cur_year,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_min,
  output logic [7:0]  set_sec,
  output logic [7:0]  set_day,
  output logic [7:0]  set_month,
  output logic [15:0] set_year,
  output logic        load_time,
  output logic        load_date,
  output logic        hold,
  output logic [2:0]  edit_field
);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_F2,
    EDIT_F1,
    EDIT_F0,
    COMMIT
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  // bit 2 = change, bit 1 = increase, bit 0 = decrease
  logic [2:0]      btn_raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      level;
  logic [2:0]      ev;
  logic [DB_W-1:0] cnt [3];
  logic            sw1;
  logic            sw2;

  assign btn_raw = {butt_change, butt_increase, butt_decrease};

  // A level is accepted after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      level <= 3'b111;
      ev    <= 3'b000;
      sw1   <= 1'b0;
      sw2   <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      sw1   <= sw_mode;
      sw2   <= sw1;
      for (int i = 0; i < 3; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          ev[i]    <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic ev_chg;
  logic up;
  logic dn;

  assign ev_chg = ev[2];
  assign up     = ev[1] & ~ev[0];
  assign dn     = ev[0] & ~ev[1];

  function automatic logic [7:0] inc8(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (v >= hi)
      return lo;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec8(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (v <= lo || v > hi)
      return hi;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] dec16(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Days in the shadow month; leap test on the last two year digits.
  logic [6:0] yy;
  logic       leap;
  logic [7:0] dim;

  always_comb begin
    yy   = 7'(set_year[7:4]) * 7'd10 + 7'(set_year[3:0]);
    leap = (yy[1:0] == 2'b00);
    case (set_month)
      8'h02:                    dim = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      default:                  dim = 8'h31;
    endcase
  end

  state_t state;
  logic   edit_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      edit_mode  <= 1'b0;
      hold       <= 1'b0;
      edit_field <= 3'b000;
      load_time  <= 1'b0;
      load_date  <= 1'b0;
      set_hour   <= 8'h00;
      set_min    <= 8'h00;
      set_sec    <= 8'h00;
      set_day    <= 8'h01;
      set_month  <= 8'h01;
      set_year   <= 16'h2024;
    end else begin
      load_time <= 1'b0;
      load_date <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_chg) begin
            edit_mode  <= sw2;
            set_hour   <= cur_hour;
            set_min    <= cur_min;
            set_sec    <= cur_sec;
            set_day    <= cur_day;
            set_month  <= cur_month;
            set_year   <= cur_year;
            state      <= EDIT_F2;
            hold       <= 1'b1;
            edit_field <= 3'b100;
          end
        end
        EDIT_F2, EDIT_F1, EDIT_F0: begin
          if (sw2 != edit_mode) begin
            state      <= IDLE;
            hold       <= 1'b0;
            edit_field <= 3'b000;
          end else if (ev_chg) begin
            if (state == EDIT_F2) begin
              state      <= EDIT_F1;
              edit_field <= 3'b010;
            end else if (state == EDIT_F1) begin
              state      <= EDIT_F0;
              edit_field <= 3'b001;
            end else begin
              state      <= COMMIT;
              edit_field <= 3'b000;
              load_time  <= ~edit_mode;
              load_date  <= edit_mode;
              if (edit_mode && set_day > dim)
                set_day <= dim;
            end
          end else if (up | dn) begin
            if (state == EDIT_F2) begin
              if (!edit_mode)
                set_hour <= up ? inc8(set_hour, 8'h00, 8'h23)
                                : dec8(set_hour, 8'h00, 8'h23);
              else
                set_day <= up ? inc8(set_day, 8'h01, dim)
                               : dec8(set_day, 8'h01, dim);
            end else if (state == EDIT_F1) begin
              if (!edit_mode)
                set_min <= up ? inc8(set_min, 8'h00, 8'h59)
                               : dec8(set_min, 8'h00, 8'h59);
              else
                set_month <= up ? inc8(set_month, 8'h01, 8'h12)
                                 : dec8(set_month, 8'h01, 8'h12);
            end else begin
              if (!edit_mode)
                set_sec <= up ? inc8(set_sec, 8'h00, 8'h59)
                               : dec8(set_sec, 8'h00, 8'h59);
              else
                set_year <= up ? inc16(set_year) : dec16(set_year);
            end
          end
        end
        COMMIT: begin
          state      <= IDLE;
          hold       <= 1'b0;
          edit_field <= 3'b000;
        end
        default: begin
          state      <= IDLE;
          hold       <= 1'b0;
          edit_field <= 3'b000;
        end
      endcase
    end
  end

endmodule
